// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the hazard tracker: producer classes, forward selects,
// and the register-match rule that both operand paths use.
package hazard_tracker_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EX_ALU  = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_sel_e;

  // x0 is hardwired zero, so a stage writing rd=0 never produces a usable value.
  function automatic logic producer_match(
    input logic             used,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd,
    input logic [1:0]       optype
  );
    return used && (rs == rd) && (rd != '0) &&
           ((optype == OP_ALU) || (optype == OP_LOAD));
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline tracking stage: destination register, producer class and the
// store-data-from-load flag, cleared asynchronously by an active-low reset.
module hazard_stage_reg
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] next_rd,
  input  logic [1:0]       next_optype,
  input  logic             next_ls,
  output logic [REG_W-1:0] rd,
  output logic [1:0]       optype,
  output logic             ls
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd     <= '0;
      optype <= OP_NONE;
      ls     <= 1'b0;
    end else begin
      rd     <= next_rd;
      optype <= next_optype;
      ls     <= next_ls;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Forwarding / load-use stall / branch flush control for a 5-stage RISC-V pipe.
// Tracks the destinations of the instructions in EX and MEM.
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic [REG_W-1:0] rd_ID,
  input  logic             rs1use,
  input  logic             rs2use,
  input  logic [1:0]       hazard_optype_ID,
  input  logic             Branch_ID,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush
);

  logic [REG_W-1:0] ex_rd, mem_rd, ex_next_rd;
  logic [1:0]       ex_optype, mem_optype, ex_next_optype;
  logic             ex_ls, ex_next_ls;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic ex_is_load, id_is_store;
  logic stall, store_from_load;

  hazard_stage_reg u_ex_stage (
    .clk         (clk),
    .rst         (rst),
    .next_rd     (ex_next_rd),
    .next_optype (ex_next_optype),
    .next_ls     (ex_next_ls),
    .rd          (ex_rd),
    .optype      (ex_optype),
    .ls          (ex_ls)
  );

  // MEM's ls flag is never consumed: the store has already taken its data in EX.
  hazard_stage_reg u_mem_stage (
    .clk         (clk),
    .rst         (rst),
    .next_rd     (ex_rd),
    .next_optype (ex_optype),
    .next_ls     (ex_ls),
    .rd          (mem_rd),
    .optype      (mem_optype),
    .ls          ()
  );

  always_comb begin
    ex_hit1  = producer_match(rs1use, rs1_ID, ex_rd, ex_optype);
    ex_hit2  = producer_match(rs2use, rs2_ID, ex_rd, ex_optype);
    mem_hit1 = producer_match(rs1use, rs1_ID, mem_rd, mem_optype);
    mem_hit2 = producer_match(rs2use, rs2_ID, mem_rd, mem_optype);

    ex_is_load  = (ex_optype == OP_LOAD);
    id_is_store = (hazard_optype_ID == OP_STORE);

    // A store's rs2 can wait for load data until EX, so only its rs1 stalls.
    stall = ex_is_load && (ex_hit1 || (ex_hit2 && !id_is_store));

    store_from_load = id_is_store && ex_is_load && (rs2_ID == ex_rd) &&
                      (ex_rd != '0) && !stall;
  end

  always_comb begin
    forward_ctrl_A = FWD_RF;
    if (ex_hit1 && ex_optype == OP_ALU)        forward_ctrl_A = FWD_EX_ALU;
    else if (mem_hit1 && mem_optype == OP_ALU)  forward_ctrl_A = FWD_MEM_ALU;
    else if (mem_hit1 && mem_optype == OP_LOAD) forward_ctrl_A = FWD_MEM_LD;

    forward_ctrl_B = FWD_RF;
    if (ex_hit2 && ex_optype == OP_ALU)        forward_ctrl_B = FWD_EX_ALU;
    else if (mem_hit2 && mem_optype == OP_ALU)  forward_ctrl_B = FWD_MEM_ALU;
    else if (mem_hit2 && mem_optype == OP_LOAD) forward_ctrl_B = FWD_MEM_LD;
  end

  always_comb begin
    ex_next_rd     = rd_ID;
    ex_next_optype = hazard_optype_ID;
    ex_next_ls     = store_from_load;
    if (stall) begin
      ex_next_rd     = '0;
      ex_next_optype = OP_NONE;
      ex_next_ls     = 1'b0;
    end
  end

  // A stall outranks a branch: the branch re-resolves next cycle with forwarded data.
  always_comb begin
    forward_ctrl_ls = ex_ls;
    PC_EN_IF        = !stall;
    reg_FD_EN       = !stall;
    reg_DE_flush    = stall;
    reg_FD_flush    = Branch_ID && !stall;
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: each ID-stage instruction pushes its
// hand-derived expected control outputs, a monitor pops and compares them.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       rs1use, rs2use;
  logic [1:0] hazard_optype_ID;
  logic       Branch_ID;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;

  localparam logic [1:0] NONE = 2'b00, ALU = 2'b01, LOAD = 2'b10, STORE = 2'b11;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fls;
    logic       pc_en;
    logic       fd_en;
    logic       fd_flush;
    logic       de_flush;
  } exp_t;

  typedef struct {
    string tag;
    exp_t  e;
  } sb_entry_t;

  sb_entry_t sb[$];
  event      sample_now;
  int        errors = 0;
  int        checks = 0;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_ID           (rs1_ID),
    .rs2_ID           (rs2_ID),
    .rd_ID            (rd_ID),
    .rs1use           (rs1use),
    .rs2use           (rs2use),
    .hazard_optype_ID (hazard_optype_ID),
    .Branch_ID        (Branch_ID),
    .forward_ctrl_A   (forward_ctrl_A),
    .forward_ctrl_B   (forward_ctrl_B),
    .forward_ctrl_ls  (forward_ctrl_ls),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_flush     (reg_FD_flush),
    .reg_DE_flush     (reg_DE_flush)
  );

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [1:0] fa, input logic [1:0] fb,
                                  input logic fls, input logic stall, input logic fd_flush);
    exp_t e;
    e.fa       = fa;
    e.fb       = fb;
    e.fls      = fls;
    e.pc_en    = !stall;
    e.fd_en    = !stall;
    e.fd_flush = fd_flush;
    e.de_flush = stall;
    return e;
  endfunction

  // Drive one ID-stage instruction at the falling edge and queue what it must produce.
  task automatic applyStimulus(input string tag,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic [1:0] op, input logic br,
                               input logic [1:0] efa, input logic [1:0] efb, input logic efls,
                               input logic estall, input logic efd_flush);
    sb_entry_t ent;
    @(negedge clk);
    rs1_ID = rs1; rs2_ID = rs2; rd_ID = rd;
    rs1use = u1;  rs2use = u2;
    hazard_optype_ID = op;
    Branch_ID = br;
    ent.tag = tag;
    ent.e   = mk_exp(efa, efb, efls, estall, efd_flush);
    sb.push_back(ent);
    #1 ->sample_now;
    #1;
  endtask

  initial begin : monitor
    sb_entry_t ent;
    forever begin
      @(sample_now);
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 8'd1, 8'd0);
      end else begin
        ent = sb.pop_front();
        checkOutput({ent.tag, ".fwdA"},     {6'd0, forward_ctrl_A}, {6'd0, ent.e.fa});
        checkOutput({ent.tag, ".fwdB"},     {6'd0, forward_ctrl_B}, {6'd0, ent.e.fb});
        checkOutput({ent.tag, ".fwdLS"},    {7'd0, forward_ctrl_ls}, {7'd0, ent.e.fls});
        checkOutput({ent.tag, ".pcEn"},     {7'd0, PC_EN_IF},       {7'd0, ent.e.pc_en});
        checkOutput({ent.tag, ".fdEn"},     {7'd0, reg_FD_EN},      {7'd0, ent.e.fd_en});
        checkOutput({ent.tag, ".fdFlush"},  {7'd0, reg_FD_flush},   {7'd0, ent.e.fd_flush});
        checkOutput({ent.tag, ".deFlush"},  {7'd0, reg_DE_flush},   {7'd0, ent.e.de_flush});
      end
    end
  end

  initial begin : timeout
    #20000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin : stimulus
    sb_entry_t ent;
    rst = 1'b0;
    rs1_ID = '0; rs2_ID = '0; rd_ID = '0;
    rs1use = 1'b0; rs2use = 1'b0; hazard_optype_ID = NONE; Branch_ID = 1'b0;

    //            tag         rs1 rs2 rd  u1 u2 op     br  fa     fb     ls stall fdfl
    applyStimulus("rst_nop",   0,  0,  0, 0, 0, NONE,  0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("rst_add",   1,  2,  5, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("rst_dep",   5,  5,  6, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    rst = 1'b1;
    applyStimulus("post_rst",  5,  1,  6, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);

    applyStimulus("alu_prod",  1,  2,  5, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("fwd_exA",   5,  1,  6, 1, 1, ALU,   0, 2'b01, 2'b00, 0, 0, 0);
    applyStimulus("fwd_memB",  1,  5,  7, 1, 1, ALU,   0, 2'b00, 2'b10, 0, 0, 0);
    applyStimulus("prio_p1",   5,  0,  5, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("prio_p2",   1,  0,  5, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("prio_ex",   5,  5,  3, 1, 1, ALU,   0, 2'b01, 2'b01, 0, 0, 0);

    applyStimulus("lw_x5",     2,  0,  5, 1, 0, LOAD,  0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("ldu_stall", 5,  0,  6, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 1, 0);
    applyStimulus("ldu_fwd",   5,  0,  6, 1, 1, ALU,   0, 2'b11, 2'b00, 0, 0, 0);

    applyStimulus("lw_x5b",    2,  0,  5, 1, 0, LOAD,  0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("sw_ld_id",  2,  5,  9, 1, 1, STORE, 0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("sw_ld_ex",  0,  0,  0, 0, 0, NONE,  0, 2'b00, 2'b00, 1, 0, 0);
    applyStimulus("sw_noprod", 9,  0,  8, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);

    applyStimulus("alu_x3",    1,  1,  3, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("sw_aluB",   2,  3,  4, 1, 1, STORE, 0, 2'b00, 2'b01, 0, 0, 0);
    applyStimulus("sw_alu_ex", 0,  0,  0, 0, 0, NONE,  0, 2'b00, 2'b00, 0, 0, 0);

    applyStimulus("x0_prod",   0,  0,  0, 1, 0, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("x0_use1",   0,  0,  1, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("x0_use2",   0,  0,  2, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);

    applyStimulus("lw_br",     4,  0,  5, 1, 0, LOAD,  0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("br_stall",  5,  1,  0, 1, 1, NONE,  1, 2'b00, 2'b00, 0, 1, 0);
    applyStimulus("br_flush",  5,  1,  0, 1, 1, NONE,  1, 2'b11, 2'b00, 0, 0, 1);

    applyStimulus("lw_rst",    4,  0,  5, 1, 0, LOAD,  0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("rst_stall", 5,  0,  6, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 1, 0);
    // Pull reset mid-cycle while the stalling instruction is still presented.
    rst = 1'b0;
    ent.tag = "mid_rst";
    ent.e   = mk_exp(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(ent);
    #1 ->sample_now;
    @(posedge clk);
    #2 rst = 1'b1;
    applyStimulus("after_rst", 5,  0,  6, 1, 1, ALU,   0, 2'b00, 2'b00, 0, 0, 0);
    applyStimulus("after_fwd", 6,  0,  7, 1, 1, ALU,   0, 2'b01, 2'b00, 0, 0, 0);

    @(negedge clk);
    checkOutput("sb_drained", sb.size()[7:0], 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 clk  input  1  sole clock, all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; 0 clears all state immediately, independent of clk.
REQ-003 rs1_ID, rs2_ID, rd_ID  input  5 each  register fields of the instruction in ID.
REQ-004 rs1use, rs2use  input  1 each  ID operand-use flags from the decode control unit.
REQ-005 hazard_optype_ID  input  2  ID producer class: 00 none, 01 ALU-writes-rd, 10 load, 11 store.
REQ-006 Branch_ID  input  1  ID redirect request: taken branch, JAL or JALR.
REQ-007 forward_ctrl_A, forward_ctrl_B  output  2 each  operand source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-008 forward_ctrl_ls  output  1  store data in EX comes from MEM load data.
REQ-009 PC_EN_IF, reg_FD_EN  output  1 each  enables for PC and IF/ID register; 0 holds.
REQ-010 reg_FD_flush, reg_DE_flush  output  1 each  clear IF/ID, or insert a bubble into ID/EX.

Function
REQ-011 Shall hold two internal tracking stages, EX{rd,optype} and MEM{rd,optype}; every edge: MEM<=EX, EX<=(stall ? {0,00} : {rd_ID,hazard_optype_ID}).
REQ-012 Producer match on stage S for source rsX: rsXuse=1, rsX_ID==rd_S, rd_S!=0, optype_S in {01,10}; rd 0 never matches.
REQ-013 forward_ctrl_A/B shall be combinational; priority: EX optype 01 -> 01; else MEM optype 01 -> 10; else MEM optype 10 -> 11; else 00.
REQ-014 stall=1 when EX optype=10 and it matches rs1, or matches rs2 with hazard_optype_ID!=11.
REQ-015 When hazard_optype_ID=11, EX optype=10, rs2_ID==rd_EX!=0 and no rs1 stall: no stall; forward_ctrl_ls latched to 1 into EX and output while that store is in EX.
REQ-016 On stall: PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1, reg_FD_flush=0; one bubble per stall cycle, so one load-use hazard costs exactly one cycle.
REQ-017 On Branch_ID=1 without stall: reg_FD_flush=1, PC_EN_IF=1, reg_FD_EN=1, reg_DE_flush=0.
REQ-018 Stall and Branch_ID together: stall wins, reg_FD_flush=0; the branch re-evaluates next cycle with forwarded data.
REQ-019 Idle/default: PC_EN_IF=1, reg_FD_EN=1, both flushes 0, all forward selects 0.
REQ-020 forward_ctrl_B forwards for store rs2 identically to REQ-013 when the producer is ALU.

Reset
REQ-021 rst=0 shall set EX and MEM to {rd=0, optype=00} and forward_ctrl_ls state to 0, without waiting for clk.
REQ-022 During and just after reset: forward selects 00, stall 0, PC_EN_IF=1, reg_FD_EN=1, flushes 0.
REQ-023 Reset asserted mid-stall shall drop the stall in the same cycle and leave no residual bubble.

Structure
REQ-024 A shared package shall define the optype encodings (NONE, ALU, LOAD, STORE) and forward-select encodings (RF, EX_ALU, MEM_ALU, MEM_LD).
REQ-025 A single sub-module, hazard_stage_reg (rd, optype, ls flag, async active-low clear), shall be instantiated twice for EX and MEM.
REQ-026 Compare and priority logic shall be purely combinational from the stage registers and ID inputs, with no other state.

Verification
REQ-027 add x5 in ID, then add x6,x5,x1 -> forward_ctrl_A=01, no stall.
REQ-028 lw x5 then add x6,x5,x0 -> stall 1 cycle (PC_EN_IF=0, reg_DE_flush=1), then forward_ctrl_A=11.
REQ-029 lw x5 then sw x5,0(x2) -> no stall, forward_ctrl_ls=1 when the sw reaches EX.
REQ-030 addi x0,x0,1 then add x1,x0,x0 -> forward selects stay 00.
REQ-031 lw x5 then beq x5,x1 with Branch_ID=1 -> stall wins, reg_FD_flush=0; next cycle reg_FD_flush=1.
REQ-032 rst pulled low during the load-use stall -> all outputs at default within the cycle, and EX/MEM cleared.
